branch_target_buffer: RTL and testbench

- Direct-mapped branch target buffer sitting between fetch and execute.
- Fetch stage presents the current PC every cycle and receives a combinational hit/target prediction.
- Execute stage reports resolved branches through the execute-stage BTB port group (pc, isBranch, isBranchTaken, irregPc), which writes the table.
- Direction prediction is not done here; the separate branch predictor owns that.

---
 rtl/branch_target_buffer_pkg.sv | 20 ++
 rtl/branch_target_buffer.sv | 50 +++++
 tb/tb_branch_target_buffer.sv | 94 +++++++++
 3 files changed

// File: rtl/branch_target_buffer_pkg.sv
// branch_target_buffer_pkg: BTB sizing, entry types and PC split helpers
package branch_target_buffer_pkg;
  localparam int BTB_PC_WIDTH = 32;
  localparam int BTB_ENTRY_NUM = 64;
  localparam int BTB_INDEX_WIDTH = $clog2(BTB_ENTRY_NUM);
  localparam int BTB_TAG_WIDTH = BTB_PC_WIDTH - BTB_INDEX_WIDTH - 2;
  typedef logic [BTB_PC_WIDTH-1:0] PC;
  typedef logic [BTB_INDEX_WIDTH-1:0] BTBIndex;
  typedef logic [BTB_TAG_WIDTH-1:0] BTBTag;
  typedef struct packed {
    BTBTag tag;
    PC target;
  } BTBEntry;
  function automatic BTBIndex btbIndex(PC pc);
    return BTBIndex'(pc >> 2);
  endfunction
  function automatic BTBTag btbTag(PC pc);
    return BTBTag'(pc >> (BTB_INDEX_WIDTH + 2));
  endfunction
endpackage

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with combinational lookup and same-cycle write bypass
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRY_NUM = BTB_ENTRY_NUM,
  parameter int PC_WIDTH = BTB_PC_WIDTH,
  parameter int INDEX_WIDTH = $clog2(ENTRY_NUM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] fetchPc,
  output logic                btbHit,
  output logic [PC_WIDTH-1:0] btbTarget,
  input  logic [PC_WIDTH-1:0] exPc,
  input  logic                exIsBranch,
  input  logic                exIsBranchTaken,
  input  logic [PC_WIDTH-1:0] exIrregPc
);
  localparam int TAG_WIDTH = PC_WIDTH - INDEX_WIDTH - 2;
  typedef logic [INDEX_WIDTH-1:0] index_t;
  typedef logic [TAG_WIDTH-1:0] tag_t;
  typedef struct packed {
    tag_t tag;
    logic [PC_WIDTH-1:0] target;
  } entry_t;
  logic [ENTRY_NUM-1:0] valid;
  entry_t entries [ENTRY_NUM];
  index_t fetchIdx, exIdx;
  tag_t fetchTag, exTag;
  logic write, bypass, storedHit;
  assign fetchIdx = index_t'(fetchPc >> 2);
  assign exIdx = index_t'(exPc >> 2);
  assign fetchTag = tag_t'(fetchPc >> (INDEX_WIDTH + 2));
  assign exTag = tag_t'(exPc >> (INDEX_WIDTH + 2));
  assign write = exIsBranch && exIsBranchTaken;
  // Only the valid vector needs reset; a write landing during reset is lost with it
  always_ff @(posedge clk or posedge rst)
    if (rst) valid <= '0;
    else if (write) valid[exIdx] <= 1'b1;
  // Tag/target storage, unconditionally overwritten on a taken branch (direct-mapped replacement)
  always_ff @(posedge clk)
    if (write) entries[exIdx] <= '{tag: exTag, target: exIrregPc};
  // Lookup with bypass: a full-word PC match on the in-flight write wins over stored state
  always_comb begin
    bypass = write && ((exPc >> 2) == (fetchPc >> 2));
    storedHit = valid[fetchIdx] && entries[fetchIdx].tag == fetchTag;
    btbHit = !rst && (bypass || storedHit);
    btbTarget = rst ? '0 : bypass ? exIrregPc : storedHit ? entries[fetchIdx].target : '0;
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed vectors against hand-computed BTB predictions
module tb_branch_target_buffer;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] fetchPc = '0, exPc = '0, exIrregPc = '0;
  logic exIsBranch = 1'b0, exIsBranchTaken = 1'b0;
  logic btbHit;
  logic [31:0] btbTarget;
  int vectors = 0, miscompares = 0;
  branch_target_buffer dut (
    .clk(clk), .rst(rst), .fetchPc(fetchPc), .btbHit(btbHit), .btbTarget(btbTarget),
    .exPc(exPc), .exIsBranch(exIsBranch), .exIsBranchTaken(exIsBranchTaken), .exIrregPc(exIrregPc)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic lookup(input string tag, input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
    fetchPc = pc;
    #1;
    check({tag, "_hit"}, {31'b0, btbHit}, {31'b0, hit});
    check({tag, "_tgt"}, btbTarget, tgt);
  endtask
  task automatic exDrive(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt);
    @(negedge clk);
    exPc = pc; exIsBranch = br; exIsBranchTaken = tk; exIrregPc = tgt;
    @(posedge clk);
    #1;
    exIsBranch = 1'b0; exIsBranchTaken = 1'b0;
  endtask
  initial begin
    fetchPc = 32'h100;
    #1;
    check("reset_hit", {31'b0, btbHit}, 32'd0);
    check("reset_tgt", btbTarget, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lookup("empty", 32'h100, 1'b0, 32'h0);
    exDrive(32'h100, 1'b1, 1'b1, 32'h200);
    lookup("basic", 32'h100, 1'b1, 32'h200);
    lookup("lowbits", 32'h102, 1'b1, 32'h200);
    lookup("nextword", 32'h104, 1'b0, 32'h0);
    exDrive(32'h200, 1'b1, 1'b1, 32'h500);
    lookup("evicted", 32'h100, 1'b0, 32'h0);
    lookup("evictor", 32'h200, 1'b1, 32'h500);
    @(negedge clk);
    exPc = 32'h300; exIsBranch = 1'b1; exIsBranchTaken = 1'b1; exIrregPc = 32'h400;
    lookup("bypass", 32'h300, 1'b1, 32'h400);
    lookup("nobypass_sameidx", 32'h200, 1'b1, 32'h500);
    @(posedge clk);
    #1;
    exIsBranch = 1'b0; exIsBranchTaken = 1'b0;
    lookup("bypass_stored", 32'h300, 1'b1, 32'h400);
    lookup("bypass_evicted", 32'h200, 1'b0, 32'h0);
    exDrive(32'h100, 1'b1, 1'b1, 32'h200);
    exDrive(32'h100, 1'b1, 1'b0, 32'h700);
    exDrive(32'h100, 1'b0, 1'b1, 32'h900);
    lookup("nottaken_nonbranch", 32'h100, 1'b1, 32'h200);
    exDrive(32'hFC, 1'b1, 1'b1, 32'h1234);
    lookup("topidx", 32'hFC, 1'b1, 32'h1234);
    lookup("topidx_alias", 32'h1FC, 1'b0, 32'h0);
    exDrive(32'h8000_0104, 1'b1, 1'b1, 32'hABC);
    lookup("hightag", 32'h8000_0104, 1'b1, 32'hABC);
    lookup("hightag_alias", 32'h104, 1'b0, 32'h0);
    exDrive(32'h104, 1'b1, 1'b1, 32'h11);
    exDrive(32'h108, 1'b1, 1'b1, 32'h22);
    exDrive(32'h10C, 1'b1, 1'b1, 32'h33);
    lookup("pop0", 32'h100, 1'b1, 32'h200);
    lookup("pop1", 32'h104, 1'b1, 32'h11);
    lookup("pop2", 32'h108, 1'b1, 32'h22);
    lookup("pop3", 32'h10C, 1'b1, 32'h33);
    @(negedge clk);
    exPc = 32'h110; exIsBranch = 1'b1; exIsBranchTaken = 1'b1; exIrregPc = 32'h44;
    #2;
    rst = 1'b1;
    lookup("arst0", 32'h100, 1'b0, 32'h0);
    lookup("arst1", 32'h104, 1'b0, 32'h0);
    lookup("arst2", 32'h108, 1'b0, 32'h0);
    lookup("arst3", 32'h10C, 1'b0, 32'h0);
    lookup("arst_bypass", 32'h110, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    exIsBranch = 1'b0; exIsBranchTaken = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lookup("dropped_write", 32'h110, 1'b0, 32'h0);
    lookup("post_reset", 32'h104, 1'b0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
